// File: rtl/bcd_serial_conv.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one operand bit per clock.
// Optional BCD_SIGNED_EN: two's-complement operand, magnitude converted, sign on neg.
module bcd_serial_conv #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
`ifdef BCD_SIGNED_EN
  ,
  output logic                  neg
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] operand;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adjusted;
  logic [BW-1:0]    scratch_next;
  logic             sticky;
  logic             ovf_next;
  logic [CW-1:0]    count;

`ifdef BCD_SIGNED_EN
  logic neg_pending;

  // The most negative operand negates to itself, which read unsigned is the right magnitude.
  assign operand = binary[WIDTH-1] ? (WIDTH'(0) - binary) : binary;
`else
  assign operand = binary;
`endif

  // Each digit is corrected independently so that doubling it carries cleanly into the next.
  always_comb begin
    adjusted = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  assign scratch_next = {adjusted[BW-2:0], shreg[WIDTH-1]};
  assign ovf_next     = sticky | adjusted[BW-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      shreg    <= '0;
      scratch  <= '0;
      sticky   <= 1'b0;
      count    <= '0;
`ifdef BCD_SIGNED_EN
      neg         <= 1'b0;
      neg_pending <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= operand;
            scratch <= '0;
            sticky  <= 1'b0;
            count   <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state   <= SHIFT;
`ifdef BCD_SIGNED_EN
            neg_pending <= binary[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          sticky  <= ovf_next;
          count   <= count - CW'(1);
          // Last step: publish the post-shift value, saturating to all nines on overflow.
          if (count == '0) begin
            bcd      <= ovf_next ? NINES : scratch_next;
            overflow <= ovf_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
`ifdef BCD_SIGNED_EN
            neg <= neg_pending;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_conv.sv
// Bench for bcd_serial_conv: three instances (6/2, 8/2, 10/4), table vectors, hand
// sequences for back-to-back, ignored start and mid-conversion reset, plus a 10-bit sweep.
module tb_bcd_serial_conv;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic        neg;
  } exp_t;

  typedef struct {
    logic [5:0] bin;
    logic [7:0] bcd;
    logic       ovf;
    logic       neg;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic       reset6, start6, busy6, done6, ovf6;
  logic [5:0] bin6;
  logic [7:0] bcd6;
  logic       reset8, start8, busy8, done8, ovf8;
  logic [7:0] bin8;
  logic [7:0] bcd8;
  logic       reset10, start10, busy10, done10, ovf10;
  logic [9:0] bin10;
  logic [15:0] bcd10;
`ifdef BCD_SIGNED_EN
  logic neg6, neg8, neg10;
`endif

  exp_t q6[$];
  exp_t q8[$];
  exp_t q10[$];

  bcd_serial_conv #(.WIDTH(6), .DIGITS(2)) u6 (
    .clk(clk), .reset(reset6), .start(start6), .binary(bin6),
    .busy(busy6), .done(done6), .bcd(bcd6), .overflow(ovf6)
`ifdef BCD_SIGNED_EN
    , .neg(neg6)
`endif
  );

  bcd_serial_conv #(.WIDTH(8), .DIGITS(2)) u8 (
    .clk(clk), .reset(reset8), .start(start8), .binary(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8)
`ifdef BCD_SIGNED_EN
    , .neg(neg8)
`endif
  );

  bcd_serial_conv #(.WIDTH(10), .DIGITS(4)) u10 (
    .clk(clk), .reset(reset10), .start(start10), .binary(bin10),
    .busy(busy10), .done(done10), .bcd(bcd10), .overflow(ovf10)
`ifdef BCD_SIGNED_EN
    , .neg(neg10)
`endif
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done6 === 1'b1) begin
      if (q6.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL spurious_done6: got done=1, required 0");
      end else begin
        exp_t e;
        e = q6.pop_front();
        check_output("bcd6", 32'(bcd6), 32'(e.bcd[7:0]));
        check_output("ovf6", 32'(ovf6), 32'(e.ovf));
`ifdef BCD_SIGNED_EN
        check_output("neg6", 32'(neg6), 32'(e.neg));
`endif
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL spurious_done8: got done=1, required 0");
      end else begin
        exp_t e;
        e = q8.pop_front();
        check_output("bcd8", 32'(bcd8), 32'(e.bcd[7:0]));
        check_output("ovf8", 32'(ovf8), 32'(e.ovf));
`ifdef BCD_SIGNED_EN
        check_output("neg8", 32'(neg8), 32'(e.neg));
`endif
      end
    end
    if (done10 === 1'b1) begin
      if (q10.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL spurious_done10: got done=1, required 0");
      end else begin
        exp_t e;
        e = q10.pop_front();
        check_output("bcd10", 32'(bcd10), 32'(e.bcd));
        check_output("ovf10", 32'(ovf10), 32'(e.ovf));
`ifdef BCD_SIGNED_EN
        check_output("neg10", 32'(neg10), 32'(e.neg));
`endif
      end
    end
  end

  function automatic exp_t model10(input int i);
    exp_t e;
    int v;
    v = i;
    e.neg = 1'b0;
    e.ovf = 1'b0;
    e.bcd = '0;
`ifdef BCD_SIGNED_EN
    if (i >= 512) begin
      v = 1024 - i;
      e.neg = 1'b1;
    end
`endif
    for (int d = 0; d < 4; d++) begin
      e.bcd[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] b, input logic o, input logic n);
    exp_t e;
    e.bcd = b;
    e.ovf = o;
    e.neg = n;
    return e;
  endfunction

  task automatic wait_done6(output int n);
    n = 0;
    while (done6 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic apply_stimulus6(input logic [5:0] b, input exp_t e);
    int n;
    q6.push_back(e);
    start6 = 1'b1;
    bin6   = b;
    tick();
    start6 = 1'b0;
    check_output("busy6_after_accept", 32'(busy6), 32'd1);
    wait_done6(n);
    check_output("latency6", 32'(n), 32'd6);
    check_output("busy6_at_done", 32'(busy6), 32'd0);
    tick();
    check_output("done6_width", 32'(done6), 32'd0);
  endtask

  task automatic apply_stimulus8(input logic [7:0] b, input exp_t e);
    int n;
    q8.push_back(e);
    start8 = 1'b1;
    bin8   = b;
    tick();
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check_output("latency8", 32'(n), 32'd8);
    tick();
  endtask

  task automatic apply_stimulus10(input int i);
    int n;
    q10.push_back(model10(i));
    start10 = 1'b1;
    bin10   = 10'(i);
    tick();
    start10 = 1'b0;
    n = 0;
    while (done10 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check_output("latency10", 32'(n), 32'd10);
    tick();
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int cnt;

`ifdef BCD_SIGNED_EN
    vecs[0] = '{6'b111011, 8'h05, 1'b0, 1'b1};
    vecs[1] = '{6'b100000, 8'h32, 1'b0, 1'b1};
    vecs[2] = '{6'd31,     8'h31, 1'b0, 1'b0};
    vecs[3] = '{6'd0,      8'h00, 1'b0, 1'b0};
    vecs[4] = '{6'b111111, 8'h01, 1'b0, 1'b1};
    vecs[5] = '{6'd42,     8'h22, 1'b0, 1'b1};
`else
    vecs[0] = '{6'd63, 8'h63, 1'b0, 1'b0};
    vecs[1] = '{6'd0,  8'h00, 1'b0, 1'b0};
    vecs[2] = '{6'd9,  8'h09, 1'b0, 1'b0};
    vecs[3] = '{6'd42, 8'h42, 1'b0, 1'b0};
    vecs[4] = '{6'd31, 8'h31, 1'b0, 1'b0};
    vecs[5] = '{6'd50, 8'h50, 1'b0, 1'b0};
`endif

    reset6 = 1'b1; reset8 = 1'b1; reset10 = 1'b1;
    start6 = 1'b0; start8 = 1'b0; start10 = 1'b0;
    bin6 = '0; bin8 = '0; bin10 = '0;
    tick();
    tick();
    reset6 = 1'b0; reset8 = 1'b0; reset10 = 1'b0;

    check_output("reset_busy6", 32'(busy6), 32'd0);
    check_output("reset_done6", 32'(done6), 32'd0);
    check_output("reset_bcd6",  32'(bcd6),  32'd0);
    check_output("reset_ovf6",  32'(ovf6),  32'd0);
    check_output("reset_bcd10", 32'(bcd10), 32'd0);
`ifdef BCD_SIGNED_EN
    check_output("reset_neg6",  32'(neg6),  32'd0);
`endif

    for (int i = 0; i < 6; i++) begin
      apply_stimulus6(vecs[i].bin, mk({8'h00, vecs[i].bcd}, vecs[i].ovf, vecs[i].neg));
    end

    // Back-to-back: start held through the whole conversion and its done cycle.
    q6.push_back(mk(16'h0000, 1'b0, 1'b0));
    start6 = 1'b1;
    bin6   = 6'd0;
    tick();
    wait_done6(n);
    check_output("b2b_latency_first", 32'(n), 32'd6);
    bin6 = 6'd9;
    q6.push_back(mk(16'h0009, 1'b0, 1'b0));
    tick();
    start6 = 1'b0;
    check_output("b2b_busy_second", 32'(busy6), 32'd1);
    wait_done6(n);
    check_output("b2b_spacing", 32'(n), 32'd6);
    tick();

    // A start pulse while busy must be dropped entirely.
`ifdef BCD_SIGNED_EN
    q6.push_back(mk(16'h0022, 1'b0, 1'b1));
`else
    q6.push_back(mk(16'h0042, 1'b0, 1'b0));
`endif
    start6 = 1'b1;
    bin6   = 6'd42;
    tick();
    start6 = 1'b0;
    tick();
    tick();
    start6 = 1'b1;
    bin6   = 6'd5;
    tick();
    start6 = 1'b0;
    wait_done6(n);
    check_output("ignore_latency", 32'(n + 3), 32'd6);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done6 === 1'b1) cnt++;
    end
    check_output("ignore_no_extra_done", 32'(cnt), 32'd0);

    // Reset mid-conversion discards the result and clears every output.
    start6 = 1'b1;
    bin6   = 6'd13;
    tick();
    start6 = 1'b0;
    tick();
    tick();
    tick();
    reset6 = 1'b1;
    tick();
    reset6 = 1'b0;
    check_output("midreset_busy6", 32'(busy6), 32'd0);
    check_output("midreset_done6", 32'(done6), 32'd0);
    check_output("midreset_bcd6",  32'(bcd6),  32'd0);
    check_output("midreset_ovf6",  32'(ovf6),  32'd0);
`ifdef BCD_SIGNED_EN
    check_output("midreset_neg6",  32'(neg6),  32'd0);
`endif
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done6 === 1'b1) cnt++;
    end
    check_output("midreset_no_done", 32'(cnt), 32'd0);
    apply_stimulus6(6'd21, mk(16'h0021, 1'b0, 1'b0));

    // Overflow saturates, then clears on the next in-range conversion.
`ifdef BCD_SIGNED_EN
    apply_stimulus8(8'h80, mk(16'h0099, 1'b1, 1'b1));
`else
    apply_stimulus8(8'd200, mk(16'h0099, 1'b1, 1'b0));
`endif
    check_output("ovf8_held", 32'(ovf8), 32'd1);
    apply_stimulus8(8'd99, mk(16'h0099, 1'b0, 1'b0));
    check_output("ovf8_cleared", 32'(ovf8), 32'd0);

    for (int i = 0; i < 1024; i++) begin
      apply_stimulus10(i);
    end

    tick();
    check_output("q6_drained",  32'(q6.size()),  32'd0);
    check_output("q8_drained",  32'(q8.size()),  32'd0);
    check_output("q10_drained", 32'(q10.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
